// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-wide load/store sequencer: default widths,
// access-size encodings, FSM state encoding and the beat-count helper.
package lsu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int BYTE_W_DEF = 8;
    localparam int ADDR_W_DEF = 32;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Number of byte beats an access of the given size needs; encodings 2 and 3 are both word.
    function automatic logic [2:0] nbeats(input logic [1:0] size);
        case (size)
            SZ_BYTE: nbeats = 3'd1;
            SZ_HALF: nbeats = 3'd2;
            default: nbeats = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Size/sign extension of the assembled little-endian load word.
// Byte and half loads take bit 7 / bit 15 as the sign when sign_en is set,
// otherwise they are zero-filled; word loads pass through untouched.
module lsu_load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF
) (
    input  logic [DATA_W-1:0] raw_data,
    input  logic [1:0]        size,
    input  logic              sign_en,
    output logic [DATA_W-1:0] ext_data
);

    localparam int HALF_W = 2 * BYTE_W;

    // Select the significant lanes for the access size and fill the upper bits.
    always_comb begin
        ext_data = raw_data;
        case (size)
            SZ_BYTE: ext_data = {{(DATA_W - BYTE_W){sign_en & raw_data[BYTE_W-1]}},
                                 raw_data[BYTE_W-1:0]};
            SZ_HALF: ext_data = {{(DATA_W - HALF_W){sign_en & raw_data[HALF_W-1]}},
                                 raw_data[HALF_W-1:0]};
            default: ext_data = raw_data;
        endcase
    end

endmodule

// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer in front of an 8-bit data memory. Each CPU access is
// split into little-endian byte beats; stores use a SETUP/STROBE pair per beat
// so mem_write falls between beats, loads collect one byte per SETUP cycle.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses with rsp_err instead of performing them bytewise.
module lsu_byte_sequencer
    import lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int BYTE_W = BYTE_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int BEAT_W = $clog2(NBYTES);
    localparam int CNT_W  = BEAT_W + 1;

    lsu_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [CNT_W-1:0]  nbeats_q, nbeats_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] bytes_q, bytes_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [BEAT_W-1:0] beat_next;
    logic              last_beat;
    logic [ADDR_W-1:0] next_addr;
    logic [BYTE_W-1:0] next_wbyte;
    logic              misalign;
    logic [DATA_W-1:0] ext_data;

    assign beat_next  = beat_q + BEAT_W'(1);
    assign last_beat  = ((CNT_W'(beat_q) + CNT_W'(1)) == nbeats_q);
    assign next_addr  = base_q + ADDR_W'(beat_next);
    assign next_wbyte = wdata_q[beat_next*BYTE_W +: BYTE_W];

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    lsu_load_extend #(
        .DATA_W (DATA_W),
        .BYTE_W (BYTE_W)
    ) u_load_extend (
        .raw_data (bytes_q),
        .size     (size_q),
        .sign_en  (signed_q),
        .ext_data (ext_data)
    );

    // State and datapath registers; async reset also drops mem_write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            nbeats_q    <= '0;
            base_q      <= '0;
            wdata_q     <= '0;
            bytes_q     <= '0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            nbeats_q    <= nbeats_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            bytes_q     <= bytes_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            write_q     <= write_d;
            err_q       <= err_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state plus the registered memory port values for the state being entered.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        nbeats_d    = nbeats_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        bytes_d     = bytes_q;
        size_d      = size_q;
        signed_d    = signed_q;
        write_d     = write_q;
        err_d       = err_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    base_d   = req_addr;
                    wdata_d  = req_wdata;
                    bytes_d  = '0;
                    size_d   = req_size;
                    signed_d = req_signed;
                    write_d  = req_write;
                    beat_d   = '0;
                    nbeats_d = CNT_W'(nbeats(req_size));
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = ST_SETUP;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata[BYTE_W-1:0];
                    end
                end
            end

            ST_SETUP: begin
                if (write_q) begin
                    state_d     = ST_STROBE;
                    mem_write_d = 1'b1;
                end else begin
                    bytes_d[beat_q*BYTE_W +: BYTE_W] = mem_rdata;
                    beat_d = beat_next;
                    if (last_beat) begin
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d  = next_addr;
                        mem_wdata_d = next_wbyte;
                    end
                end
            end

            ST_STROBE: begin
                beat_d = beat_next;
                if (last_beat) begin
                    state_d = ST_RESP;
                end else begin
                    state_d     = ST_SETUP;
                    mem_addr_d  = next_addr;
                    mem_wdata_d = next_wbyte;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and response outputs decoded from the current state.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = (rsp_valid && !write_q && !err_q) ? ext_data : '0;
    end

    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Self-checking bench for lsu_byte_sequencer: a table of load/store vectors
// run through a response scoreboard, followed by hand-written sequences for
// write pulse shape, response back-pressure and reset during a store.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_lsu_byte_sequencer;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [0:255];
    logic        tb_we;
    logic [7:0]  tb_waddr;
    logic [7:0]  tb_wdata;

    int n_total = 0;
    int n_bad   = 0;
    int wr_cycles = 0;
    int wr_rises  = 0;
    int bad_addr  = 0;
    logic wr_prev = 1'b0;

    vec_t sb_q[$];
    vec_t tbl[14];

    always #5 clk = ~clk;

    lsu_byte_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Byte memory model: commits a strobed byte at the clock edge; bench preload port otherwise.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    assign mem_rdata = mem[mem_addr[7:0]];

    // Write-pulse monitor: counts strobe cycles, rising edges and out-of-range addresses.
    always @(posedge clk) begin
        if (mem_write) begin
            wr_cycles++;
            if (!wr_prev) wr_rises++;
            if (mem_addr[31:8] != 24'h000000 && mem_addr[31:8] != 24'hFFFFFF) bad_addr++;
        end
        wr_prev = mem_write;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    function automatic vec_t mk(input string name, input logic wr, input logic [1:0] size,
                                input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic drive_req(input vec_t v);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.size;
        req_signed = v.sgn;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
    endtask

    // Drive one request at a negedge, confirm it is accepted, and queue its expected response.
    task automatic apply_stimulus(input vec_t v);
        drive_req(v);
        check({v.name, "_ready"}, 32'(req_ready), 32'd1);
        sb_q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_output(input int lat);
        vec_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("[TB] FAIL scoreboard_empty: actual=0 entries required=1");
            return;
        end
        e = sb_q.pop_front();
        check({e.name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({e.name, "_rdata"}, rsp_rdata, e.exp_rdata);
        check({e.name, "_err"}, 32'(rsp_err), 32'(e.exp_err));
        check({e.name, "_lat"}, 32'(lat), 32'(e.exp_lat));
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({name, "_rsp_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int   lat;
        int   c0;
        int   r0;
        vec_t va;
        vec_t vb;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(8'h31, 8'h34); preload(8'h32, 8'h12);
        preload(8'h40, 8'hCD); preload(8'h41, 8'hAB);
        preload(8'hFE, 8'h00); preload(8'hFF, 8'h00);
        preload(8'h00, 8'h00); preload(8'h01, 8'h00);

        tbl[0]  = mk("st_w_10",    1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hA1B2C3D4, 32'h0, 1'b0, 9);
        tbl[1]  = mk("ld_w_10",    1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'hA1B2C3D4, 1'b0, 5);
        tbl[2]  = mk("st_b_30",    1'b1, 2'd0, 1'b0, 32'h0000_0030, 32'hDEADBE80, 32'h0, 1'b0, 3);
        tbl[3]  = mk("ld_b_30_s",  1'b0, 2'd0, 1'b1, 32'h0000_0030, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        tbl[4]  = mk("ld_b_30_u",  1'b0, 2'd0, 1'b0, 32'h0000_0030, 32'h0, 32'h00000080, 1'b0, 2);
        tbl[5]  = mk("ld_h_31",    1'b0, 2'd1, 1'b0, 32'h0000_0031, 32'h0,
                     TRAP ? 32'h0 : 32'h00001234, TRAP, TRAP ? 1 : 3);
        tbl[6]  = mk("ld_h_40_s",  1'b0, 2'd1, 1'b1, 32'h0000_0040, 32'h0, 32'hFFFFABCD, 1'b0, 3);
        tbl[7]  = mk("ld_h_12_u",  1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 32'h0000A1B2, 1'b0, 3);
        tbl[8]  = mk("ld_w3_10_s", 1'b0, 2'd3, 1'b1, 32'h0000_0010, 32'h0, 32'hA1B2C3D4, 1'b0, 5);
        tbl[9]  = mk("st_h_50",    1'b1, 2'd1, 1'b0, 32'h0000_0050, 32'h1234BEEF, 32'h0, 1'b0, 5);
        tbl[10] = mk("ld_h_50_s",  1'b0, 2'd1, 1'b1, 32'h0000_0050, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
        tbl[11] = mk("st_w_wrap",  1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h89ABCDEF,
                     32'h0, TRAP, TRAP ? 1 : 9);
        tbl[12] = mk("ld_w_wrap",  1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0,
                     TRAP ? 32'h0 : 32'h89ABCDEF, TRAP, TRAP ? 1 : 5);
        tbl[13] = mk("ld_b_11_s",  1'b0, 2'd0, 1'b1, 32'h0000_0011, 32'h0, 32'hFFFFFFC3, 1'b0, 2);

        @(negedge clk);
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i]);
            wait_rsp(lat);
            check_output(lat);
            finish_rsp(tbl[i].name);
        end

        check("mem_word_10", mem_word(8'h10), 32'hA1B2C3D4);
        check("mem_byte_30", 32'(mem[8'h30]), 32'h80);
        check("mem_half_50", {mem[8'h51], mem[8'h50]}, 32'hBEEF);
        check("mem_word_wrap", mem_word(8'hFE), TRAP ? 32'h0 : 32'h89ABCDEF);
        check("mem_addr_range", 32'(bad_addr), 32'd0);

        $display("[TB] word store pulse shape");
        preload(8'h20, 8'h00); preload(8'h21, 8'h00);
        preload(8'h22, 8'h00); preload(8'h23, 8'h00);
        @(negedge clk);
        c0 = wr_cycles;
        r0 = wr_rises;
        va = mk("st_w_20", 1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h55555555, 32'h0, 1'b0, 9);
        apply_stimulus(va);
        wait_rsp(lat);
        check_output(lat);
        finish_rsp(va.name);
        check("st_w_20_pulses", 32'(wr_rises - r0), 32'd4);
        check("st_w_20_high_cycles", 32'(wr_cycles - c0), 32'd4);
        check("mem_word_20", mem_word(8'h20), 32'h55555555);

        $display("[TB] response back-pressure");
        va = mk("hold_ld_w", 1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 32'hA1B2C3D4, 1'b0, 5);
        vb = mk("post_hold_ld_b", 1'b0, 2'd0, 1'b0, 32'h0000_0030, 32'h0, 32'h00000080, 1'b0, 2);
        apply_stimulus(va);
        wait_rsp(lat);
        check_output(lat);
        drive_req(vb);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'hA1B2C3D4);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_rsp_drop", 32'(rsp_valid), 32'd0);
        check("hold_ready_after", 32'(req_ready), 32'd1);
        sb_q.push_back(vb);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("post_hold_accepted", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        check_output(lat);
        finish_rsp(vb.name);

        $display("[TB] reset during store beat 2");
        preload(8'h60, 8'h11); preload(8'h61, 8'h11);
        preload(8'h62, 8'h11); preload(8'h63, 8'h11);
        @(negedge clk);
        va = mk("rst_st_w", 1'b1, 2'd2, 1'b0, 32'h0000_0060, 32'hDDCCBBAA, 32'h0, 1'b0, 9);
        drive_req(va);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_in_strobe", 32'(mem_write), 32'd1);
        check("rst_strobe_addr", mem_addr, 32'h0000_0062);
        rst_n = 1'b0;
        #1;
        check("rst_wr_drop", 32'(mem_write), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_partial_word", mem_word(8'h60), 32'h1111BBAA);
        check("rst_after_ready", 32'(req_ready), 32'd1);
        check("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_after_mem_addr", mem_addr, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
